// File: rtl/varredura_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package varredura_pkg;

  // Scanner states: all anodes off between digits, or one digit lit.
  typedef enum logic [0:0] {
    GUARDA = 1'b0,
    ACESO  = 1'b1
  } estado_t;

  // Largest code the downstream decoder accepts.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Widest display the scanner supports.
  localparam int MAX_DIGITOS = 8;

  // Mask with the low n bits set; used as the "all anodes off" pattern.
  function automatic logic [MAX_DIGITOS-1:0] anodos_off(input int n);
    logic [MAX_DIGITOS-1:0] m;
    m = {MAX_DIGITOS{1'b0}};
    for (int i = 0; i < MAX_DIGITOS; i++) begin
      if (i < n) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Full-width all-off pattern.
  localparam logic [MAX_DIGITOS-1:0] ANODOS_OFF = anodos_off(MAX_DIGITOS);

  // True for nibbles the decoder must never see (A..F).
  function automatic logic nibble_invalido(input logic [3:0] n);
    return (n > BCD_MAX);
  endfunction

endpackage

// File: rtl/contador_modulo.sv
// Dwell-time counter: counts up to 'ultimo' and wraps, raising 'fim' on the last count.
module contador_modulo #(
  parameter int LARGURA = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               limpa,
  input  logic [LARGURA-1:0] ultimo,
  output logic [LARGURA-1:0] contagem,
  output logic               fim
);

  localparam logic [LARGURA-1:0] ZERO = {LARGURA{1'b0}};
  localparam logic [LARGURA-1:0] UM   = LARGURA'(1);

  assign fim = (contagem == ultimo);

  // Count, returning to zero on terminal count (state change) or when cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= ZERO;
    end else if (limpa || fim) begin
      contagem <= ZERO;
    end else begin
      contagem <= contagem + UM;
    end
  end

endmodule

// File: rtl/varredura_display.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Outputs are registered from the next-state values so they line up with the FSM state.
module varredura_display
  import varredura_pkg::*;
#(
  parameter int NUM_DIGITOS   = 4,
  parameter int CICLOS_DIGITO = 50000,
  parameter int CICLOS_GUARDA = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     habilita,
  input  logic                     suprime_zeros,
  input  logic [4*NUM_DIGITOS-1:0] valores,
  output logic [3:0]               digito,
  output logic [NUM_DIGITOS-1:0]   anodos,
  output logic                     apagado,
  output logic                     inicio_quadro
);

  localparam int MAIOR_CICLO  = (CICLOS_DIGITO > CICLOS_GUARDA) ? CICLOS_DIGITO : CICLOS_GUARDA;
  localparam int LARGURA_CONT = $clog2(MAIOR_CICLO);
  localparam int LARGURA_IND  = $clog2(NUM_DIGITOS);

  localparam logic [NUM_DIGITOS-1:0]   TODOS_OFF = NUM_DIGITOS'(anodos_off(NUM_DIGITOS));
  localparam logic [NUM_DIGITOS-1:0]   ANODO_UM  = NUM_DIGITOS'(1);
  localparam logic [LARGURA_IND-1:0]   IND_ZERO  = {LARGURA_IND{1'b0}};
  localparam logic [LARGURA_IND-1:0]   IND_UM    = LARGURA_IND'(1);
  localparam logic [LARGURA_IND-1:0]   IND_ULT   = LARGURA_IND'(NUM_DIGITOS - 1);
  localparam logic [LARGURA_CONT-1:0]  ULT_DIG   = LARGURA_CONT'(CICLOS_DIGITO - 1);
  localparam logic [LARGURA_CONT-1:0]  ULT_GUA   = LARGURA_CONT'(CICLOS_GUARDA - 1);

  estado_t                   estado_r, estado_s;
  logic [LARGURA_IND-1:0]    indice_r, indice_s;
  logic [4*NUM_DIGITOS-1:0]  snap_val_r, snap_val_s;
  logic                      snap_sup_r, snap_sup_s;

  logic [LARGURA_CONT-1:0]   ultimo_s;
  logic [LARGURA_CONT-1:0]   contador_s;
  logic                      fim_s;

  logic [3:0]                nib_s [NUM_DIGITOS];
  logic [NUM_DIGITOS-1:0]    zeros_acima_s;
  logic [3:0]                nibble_s;
  logic                      branco_s;

  logic [NUM_DIGITOS-1:0]    anodos_s;
  logic [3:0]                digito_s;
  logic                      apagado_s;
  logic                      inicio_s;

  assign ultimo_s = (estado_r == ACESO) ? ULT_DIG : ULT_GUA;

  contador_modulo #(
    .LARGURA (LARGURA_CONT)
  ) u_contador (
    .clock    (clock),
    .reset    (reset),
    .limpa    (~habilita),
    .ultimo   (ultimo_s),
    .contagem (contador_s),
    .fim      (fim_s)
  );

  // Next state, digit index and frame snapshot.
  always_comb begin
    estado_s   = estado_r;
    indice_s   = indice_r;
    snap_val_s = snap_val_r;
    snap_sup_s = snap_sup_r;
    if (!habilita) begin
      estado_s = GUARDA;
      indice_s = IND_ZERO;
    end else begin
      case (estado_r)
        GUARDA: begin
          if (fim_s) begin
            estado_s = ACESO;
            if (indice_r == IND_ZERO) begin
              snap_val_s = valores;
              snap_sup_s = suprime_zeros;
            end else begin
              snap_val_s = snap_val_r;
              snap_sup_s = snap_sup_r;
            end
          end else begin
            estado_s = GUARDA;
          end
        end
        ACESO: begin
          if (fim_s) begin
            estado_s = GUARDA;
            if (indice_r == IND_ULT) begin
              indice_s = IND_ZERO;
            end else begin
              indice_s = indice_r + IND_UM;
            end
          end else begin
            estado_s = ACESO;
          end
        end
        default: begin
          estado_s = GUARDA;
          indice_s = IND_ZERO;
        end
      endcase
    end
  end

  // Blanking of the digit about to be shown: invalid code or leading zero.
  always_comb begin
    logic acumula;
    acumula = 1'b1;
    for (int i = NUM_DIGITOS - 1; i >= 0; i--) begin
      nib_s[i]         = snap_val_s[4*i +: 4];
      acumula          = acumula & (snap_val_s[4*i +: 4] == 4'd0);
      zeros_acima_s[i] = acumula;
    end
    nibble_s = nib_s[indice_s];
    if (nibble_invalido(nibble_s)) begin
      branco_s = 1'b1;
    end else if (snap_sup_s && (indice_s != IND_ZERO) && zeros_acima_s[indice_s]) begin
      branco_s = 1'b1;
    end else begin
      branco_s = 1'b0;
    end
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    anodos_s  = TODOS_OFF;
    digito_s  = 4'd0;
    apagado_s = 1'b1;
    if ((estado_s == ACESO) && !branco_s) begin
      anodos_s  = ~(ANODO_UM << indice_s);
      digito_s  = nibble_s;
      apagado_s = 1'b0;
    end else begin
      anodos_s  = TODOS_OFF;
      digito_s  = 4'd0;
      apagado_s = 1'b1;
    end
    inicio_s = (estado_r == GUARDA) && (estado_s == ACESO) && (indice_s == IND_ZERO);
  end

  // FSM and snapshot registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r   <= GUARDA;
      indice_r   <= IND_ZERO;
      snap_val_r <= {(4*NUM_DIGITOS){1'b0}};
      snap_sup_r <= 1'b0;
    end else begin
      estado_r   <= estado_s;
      indice_r   <= indice_s;
      snap_val_r <= snap_val_s;
      snap_sup_r <= snap_sup_s;
    end
  end

  // Registered outputs; reset turns every anode off immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anodos        <= TODOS_OFF;
      digito        <= 4'd0;
      apagado       <= 1'b1;
      inicio_quadro <= 1'b0;
    end else begin
      anodos        <= anodos_s;
      digito        <= digito_s;
      apagado       <= apagado_s;
      inicio_quadro <= inicio_s;
    end
  end

endmodule

// File: tb/tb_varredura_display.sv
// Self-checking bench for varredura_display: frame-position reference model plus literal checks.
module tb_varredura_display;

  localparam int N = 4;
  localparam int D = 3;
  localparam int G = 1;
  localparam int P = N * (G + D);

  logic          clock;
  logic          reset;
  logic          habilita;
  logic          suprime_zeros;
  logic [15:0]   valores;
  logic [3:0]    digito;
  logic [3:0]    anodos;
  logic          apagado;
  logic          inicio_quadro;
  logic [9:0]    saida;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: enabled edges since the last forced restart, and the frame snapshot.
  int          k      = 0;
  logic [15:0] m_val  = 16'h0000;
  logic        m_sup  = 1'b0;

  varredura_display #(
    .NUM_DIGITOS   (N),
    .CICLOS_DIGITO (D),
    .CICLOS_GUARDA (G)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .habilita      (habilita),
    .suprime_zeros (suprime_zeros),
    .valores       (valores),
    .digito        (digito),
    .anodos        (anodos),
    .apagado       (apagado),
    .inicio_quadro (inicio_quadro)
  );

  assign saida = {anodos, digito, apagado, inicio_quadro};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic confere(input string nome, input logic [9:0] obtido, input logic [9:0] exigido);
    n_total++;
    if (obtido === exigido) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got anodos/digito/apagado/inicio=%b required %b at t=%0t",
               nome, obtido, exigido, $time);
    end
  endtask

  // Expected outputs from the frame position: each slot is G guard cycles then D lit cycles.
  function automatic logic [9:0] esperado(input int kk, input logic [15:0] v, input logic s);
    int pos, slot, off;
    logic [3:0] nib, an;
    logic blank, allz, ini;
    pos  = kk % P;
    slot = pos / (G + D);
    off  = pos % (G + D);
    if (off < G) return {4'b1111, 4'd0, 1'b1, 1'b0};
    ini   = (slot == 0) && (off == G);
    nib   = 4'(v >> (4 * slot));
    blank = (nib > 4'd9);
    if (s && slot != 0) begin
      allz = 1'b1;
      for (int j = slot; j < N; j++) begin
        if (4'(v >> (4 * j)) != 4'd0) allz = 1'b0;
      end
      if (allz) blank = 1'b1;
    end
    if (blank) return {4'b1111, 4'd0, 1'b1, ini};
    an = 4'b1111;
    an[slot] = 1'b0;
    return {an, nib, 1'b0, ini};
  endfunction

  // Model update on every edge; reset and disable restart the frame position.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      k     <= 0;
      m_val <= 16'h0000;
      m_sup <= 1'b0;
    end else if (!habilita) begin
      k <= 0;
    end else begin
      k <= k + 1;
      if ((k + 1) % P == G) begin
        m_val <= valores;
        m_sup <= suprime_zeros;
      end
    end
  end

  // Per-cycle comparison against the model, sampled away from the edge.
  always @(posedge clock) begin
    #3;
    confere("ciclo", saida, esperado(k, m_val, m_sup));
  end

  task automatic avanca(input int n);
    repeat (n) @(posedge clock);
    #3;
  endtask

  task automatic espera_inicio();
    bit achou;
    achou = 1'b0;
    for (int i = 0; i < 64 && !achou; i++) begin
      @(posedge clock);
      #3;
      if (inicio_quadro === 1'b1) achou = 1'b1;
    end
    n_total++;
    if (achou) begin
      n_pass++;
    end else begin
      $display("FAIL espera_inicio: got no inicio_quadro within 64 cycles, required a pulse");
    end
  endtask

  function automatic logic [15:0] valor_aleatorio();
    logic [15:0] v;
    int r;
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      v[4*i +: 4] = 4'd0;
      else if (r == 1) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else             v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    reset         = 1'b1;
    habilita      = 1'b1;
    suprime_zeros = 1'b0;
    valores       = 16'h1234;

    // Reset state
    @(posedge clock); #3;
    confere("reset_estado", saida, 10'b1111_0000_1_0);
    #3 reset = 1'b0;

    // Basic scan
    avanca(1);  confere("partida",   saida, 10'b1110_0100_0_1);
    avanca(1);  confere("dig0_seg",  saida, 10'b1110_0100_0_0);
    avanca(2);  confere("guarda01",  saida, 10'b1111_0000_1_0);
    avanca(1);  confere("dig1",      saida, 10'b1101_0011_0_0);
    avanca(12); confere("periodo16", saida, 10'b1110_0100_0_1);

    // Leading-zero suppression
    #3 valores = 16'h0045; suprime_zeros = 1'b1;
    espera_inicio();
    confere("sup_dig0", saida, 10'b1110_0101_0_1);
    avanca(4); confere("sup_dig1", saida, 10'b1101_0100_0_0);
    avanca(4); confere("sup_dig2", saida, 10'b1111_0000_1_0);
    avanca(4); confere("sup_dig3", saida, 10'b1111_0000_1_0);
    #3 valores = 16'h0000;
    espera_inicio();
    confere("zero_dig0", saida, 10'b1110_0000_0_1);
    avanca(4); confere("zero_dig1", saida, 10'b1111_0000_1_0);

    // Invalid code
    #3 valores = 16'h12A4; suprime_zeros = 1'b0;
    espera_inicio();
    confere("inv_dig0", saida, 10'b1110_0100_0_1);
    avanca(4); confere("inv_dig1", saida, 10'b1111_0000_1_0);
    avanca(4); confere("inv_dig2", saida, 10'b1011_0010_0_0);
    avanca(4); confere("inv_dig3", saida, 10'b0111_0001_0_0);

    // Snapshot coherence
    #3 valores = 16'h1234;
    espera_inicio();
    avanca(4); confere("snap_dig1", saida, 10'b1101_0011_0_0);
    #3 valores = 16'h5678;
    avanca(4); confere("snap_dig2", saida, 10'b1011_0010_0_0);
    avanca(4); confere("snap_dig3", saida, 10'b0111_0001_0_0);
    avanca(4); confere("snap_novo", saida, 10'b1110_1000_0_1);

    // Enable drop during digit 2
    avanca(8); confere("hab_dig2", saida, 10'b1011_0110_0_0);
    #3 habilita = 1'b0;
    avanca(1); confere("hab_off",  saida, 10'b1111_0000_1_0);
    avanca(2); confere("hab_off3", saida, 10'b1111_0000_1_0);
    #3 habilita = 1'b1;
    avanca(1); confere("hab_volta", saida, 10'b1110_1000_0_1);

    // Asynchronous reset mid-ACESO
    avanca(1); confere("pre_reset", saida, 10'b1110_1000_0_0);
    #3 reset = 1'b1;
    #1 confere("reset_assinc", saida, 10'b1111_0000_1_0);
    @(posedge clock);
    @(posedge clock);
    #6 reset = 1'b0;
    avanca(1); confere("pos_reset", saida, 10'b1110_1000_0_1);

    // Randomized run against the model
    repeat (60) begin
      #3;
      valores       = valor_aleatorio();
      suprime_zeros = 1'($urandom_range(0, 1));
      habilita      = ($urandom_range(0, 7) != 0);
      avanca($urandom_range(1, 30));
    end
    #3 habilita = 1'b1;
    avanca(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
